dvp_pattern_tx: RTL and testbench

//  DVP (OV5640-style) camera-port transmitter: emits RGB565 test frames on VSYNC/HREF/DATA[7:0],
//  one byte per CLK, two bytes per pixel. Stands in for the sensor so the camera capture path
//  (capture -> BRAM -> VGA) runs without the OV5640. Downstream samples VSYNC/HREF/DATA on rising CLK.

---
 rtl/dvp_pattern_tx_pkg.sv | 43 ++++
 rtl/dvp_pattern_tx_if.sv | 9 +
 rtl/dvp_pattern_tx_pixel_gen.sv | 40 ++++
 rtl/dvp_pattern_tx.sv | 167 ++++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dvp_pattern_tx_pkg.sv
// Shared types and RGB565 constants for the DVP test-pattern transmitter.
package dvp_pattern_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GREY  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_ADDR  = 2'd3
  } pattern_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_tx_if.sv
// DVP camera bus: frame sync, line valid and byte data.
interface dvp_pattern_tx_if;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] DATA;

  modport master (output VSYNC, output HREF, output DATA);
  modport slave  (input  VSYNC, input  HREF, input  DATA);
endinterface

// File: rtl/dvp_pattern_tx_pixel_gen.sv
// RGB565 pixel generator with one register stage; loads on i_load.
module dvp_pattern_tx_pixel_gen
  import dvp_pattern_tx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  pattern_e    i_pat,
  input  logic [7:2]  i_x,
  input  logic        i_y5,
  input  logic [2:0]  i_bar,
  input  logic [15:0] i_addr,
  input  logic        i_frame_lsb,
  output logic [15:0] o_pixel
);

  logic [15:0] w_pixel;
  logic [15:0] r_pixel;

  always_comb begin
    w_pixel = '0;
    case (i_pat)
      PAT_BARS:  w_pixel = bar_color(i_bar);
      PAT_GREY:  w_pixel = {i_x[7:3], i_x[7:2], i_x[7:3]};
      PAT_CHECK: w_pixel = (i_x[5] ^ i_y5 ^ i_frame_lsb) ? '1 : '0;
      PAT_ADDR:  w_pixel = i_addr;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pixel <= '0;
    end else if (i_load) begin
      r_pixel <= w_pixel;
    end
  end

  assign o_pixel = r_pixel;

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV5640-style DVP transmitter: RGB565 test frames on VSYNC/HREF/DATA,
// one byte per CLK, two bytes per pixel, all outputs registered.
module dvp_pattern_tx
  import dvp_pattern_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 4,
  parameter int unsigned V_BACK      = 16,
  parameter int unsigned V_FRONT     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN_TX,
  input  logic [1:0]        PATTERN_SEL,
  dvp_pattern_tx_if.master  dvp,
  output logic              FRAME_DONE,
  output logic [15:0]       FRAME_CNT
);

  localparam logic [15:0] XB_LAST     = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] XB_ACT      = 16'(2 * H_ACTIVE);
  localparam logic [15:0] XB_ACT_LAST = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] VS_LAST     = 16'(VSYNC_LINES - 1);
  localparam logic [15:0] VB_LAST     = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST     = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST     = 16'(V_FRONT - 1);
  localparam logic [15:0] PX_LAST     = 16'(H_ACTIVE - 1);
  localparam logic [15:0] BAR_LAST    = 16'(H_ACTIVE / 8 - 1);

  state_e      r_state;
  logic [15:0] r_xb;
  logic [15:0] r_line;
  pattern_e    r_pat;
  logic [15:0] r_px;
  logic [15:0] r_ay;
  logic [2:0]  r_bar;
  logic [15:0] r_bar_cnt;
  logic [15:0] r_addr;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_data;
  logic        r_frame_done;
  logic [15:0] r_frame_cnt;

  logic        w_line_end;
  logic        w_active_byte;
  logic        w_next_active_line;
  logic        w_load;
  logic        w_frame_start;
  logic [15:0] w_pixel;

  assign w_line_end    = (r_xb == XB_LAST);
  assign w_active_byte = (r_state == ST_ACTIVE) && (r_xb < XB_ACT);
  assign w_next_active_line = w_line_end &&
      (((r_state == ST_VBACK) && (r_line == VB_LAST)) ||
       ((r_state == ST_ACTIVE) && (r_line != VA_LAST)));
  // The pixel register is loaded one byte ahead of its first (high) byte:
  // on every odd active byte except the last, and on the cycle before an active line.
  assign w_load = (w_active_byte && r_xb[0] && (r_xb != XB_ACT_LAST)) || w_next_active_line;
  assign w_frame_start = ((r_state == ST_IDLE) && EN_TX) ||
      ((r_state == ST_VFRONT) && w_line_end && (r_line == VF_LAST) && EN_TX);

  dvp_pattern_tx_pixel_gen u_pixel_gen (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_load      (w_load),
    .i_pat       (r_pat),
    .i_x         (r_px[7:2]),
    .i_y5        (r_ay[5]),
    .i_bar       (r_bar),
    .i_addr      (r_addr),
    .i_frame_lsb (r_frame_cnt[0]),
    .o_pixel     (w_pixel)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_xb         <= '0;
      r_line       <= '0;
      r_pat        <= PAT_BARS;
      r_px         <= '0;
      r_ay         <= '0;
      r_bar        <= '0;
      r_bar_cnt    <= '0;
      r_addr       <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_vsync      <= (r_state == ST_VSYNC);
      r_href       <= w_active_byte;
      r_data       <= w_active_byte ? (r_xb[0] ? w_pixel[7:0] : w_pixel[15:8]) : '0;
      r_frame_done <= 1'b0;

      if (w_frame_start) begin
        r_pat     <= pattern_e'(PATTERN_SEL);
        r_px      <= '0;
        r_ay      <= '0;
        r_bar     <= '0;
        r_bar_cnt <= '0;
        r_addr    <= '0;
      end else if (w_load) begin
        r_addr <= r_addr + 16'd1;
        if (r_px == PX_LAST) begin
          r_px      <= '0;
          r_bar     <= '0;
          r_bar_cnt <= '0;
          r_ay      <= r_ay + 16'd1;
        end else begin
          r_px <= r_px + 16'd1;
          if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar     <= r_bar + 3'd1;
          end else begin
            r_bar_cnt <= r_bar_cnt + 16'd1;
          end
        end
      end

      if (r_state == ST_IDLE) begin
        if (EN_TX) begin
          r_state <= ST_VSYNC;
          r_xb    <= '0;
          r_line  <= '0;
        end
      end else if (!w_line_end) begin
        r_xb <= r_xb + 16'd1;
      end else begin
        r_xb   <= '0;
        r_line <= r_line + 16'd1;
        case (r_state)
          ST_VSYNC: if (r_line == VS_LAST) begin
            r_state <= ST_VBACK;
            r_line  <= '0;
          end
          ST_VBACK: if (r_line == VB_LAST) begin
            r_state <= ST_ACTIVE;
            r_line  <= '0;
          end
          ST_ACTIVE: if (r_line == VA_LAST) begin
            r_state <= ST_VFRONT;
            r_line  <= '0;
          end
          ST_VFRONT: if (r_line == VF_LAST) begin
            r_line       <= '0;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            r_state      <= EN_TX ? ST_VSYNC : ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign dvp.VSYNC  = r_vsync;
  assign dvp.HREF   = r_href;
  assign dvp.DATA   = r_data;
  assign FRAME_DONE = r_frame_done;
  assign FRAME_CNT  = r_frame_cnt;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx: frame timeline and pixel bytes from a reference model.
module tb_dvp_pattern_tx;

  localparam int H     = 16;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int L     = 2 * H + HB;
  localparam int FRAME = L * (VS + VB + VA + VF);

  typedef struct {
    int         s;
    logic [1:0] pat;
    bit         lsb;
  } frame_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        EN_TX = 1'b0;
  logic [1:0]  PATTERN_SEL = 2'd0;
  logic        FRAME_DONE;
  logic [15:0] FRAME_CNT;

  dvp_pattern_tx_if dvp_bus ();

  dvp_pattern_tx #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB),
    .VSYNC_LINES (VS),
    .V_BACK      (VB),
    .V_FRONT     (VF)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .EN_TX       (EN_TX),
    .PATTERN_SEL (PATTERN_SEL),
    .dvp         (dvp_bus),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_CNT   (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done = 0;
  logic [15:0] exp_fcnt = '0;
  frame_t     q_frame[$];
  logic [7:0] q_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_pixel(input logic [1:0] pat, input int x, input int y, input bit lsb);
    int v;
    case (pat)
      2'd0: begin
        case (x / (H / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: begin
        v = x % 256;
        return 16'(((v >> 3) << 11) | ((v >> 2) << 5) | (v >> 3));
      end
      2'd2: return ((((x >> 5) ^ (y >> 5) ^ int'(lsb)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: return 16'((y * H + x) % 65536);
    endcase
  endfunction

  task automatic push_frame(input int s, input logic [1:0] pat, input bit lsb);
    frame_t f;
    logic [15:0] p;
    f.s = s;
    f.pat = pat;
    f.lsb = lsb;
    q_frame.push_back(f);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < H; x++) begin
        p = ref_pixel(pat, x, y, lsb);
        q_data.push_back(p[15:8]);
        q_data.push_back(p[7:0]);
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic run_frames(input int nf, input logic [1:0] p0, input bit mix);
    logic [1:0] pats[$];
    int s;
    int sk;
    @(posedge CLK);
    #1;
    s = cyc + 2;
    pats.push_back(p0);
    for (int k = 1; k < nf; k++) pats.push_back(mix ? 2'($urandom_range(0, 3)) : p0);
    for (int k = 0; k < nf; k++) push_frame(s + k * FRAME, pats[k], 1'((done + k) & 1));
    PATTERN_SEL = p0;
    EN_TX = 1'b1;
    for (int k = 0; k < nf; k++) begin
      sk = s + k * FRAME;
      wait_cyc(sk + 10);
      PATTERN_SEL = 2'($urandom);
      wait_cyc(sk + 100);
      if (k < nf - 1) begin
        PATTERN_SEL = pats[k + 1];
      end else begin
        wait_cyc(sk + int'($urandom_range(100, 240)));
        EN_TX = 1'b0;
      end
    end
    wait_cyc(s + nf * FRAME + 5);
    done += nf;
  endtask

  // Monitor: frame timeline from the elapsed-cycle position, bytes popped whenever HREF is high.
  always @(negedge CLK) begin
    bit act;
    bit ev, eh, efd;
    int t, line, xb;
    if (RESET) begin
      exp_fcnt = '0;
      check("rst_vsync", dvp_bus.VSYNC, 0);
      check("rst_href", dvp_bus.HREF, 0);
      check("rst_data", dvp_bus.DATA, 0);
      check("rst_fcnt", FRAME_CNT, 0);
    end else begin
      act = (q_frame.size() > 0) && (cyc >= q_frame[0].s);
      t = act ? cyc - q_frame[0].s : 0;
      line = t / L;
      xb = t % L;
      ev = act && (line < VS);
      eh = act && (line >= VS + VB) && (line < VS + VB + VA) && (xb < 2 * H);
      efd = act && (t == FRAME - 1);
      if (efd) exp_fcnt = exp_fcnt + 16'd1;
      check("vsync", dvp_bus.VSYNC, ev);
      check("href", dvp_bus.HREF, eh);
      check("frame_done", FRAME_DONE, efd);
      check("frame_cnt", FRAME_CNT, exp_fcnt);
      if (dvp_bus.HREF) begin
        if (q_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_underflow at cycle %0d: got byte %0h with no expected byte queued", cyc, dvp_bus.DATA);
        end else begin
          check("data", dvp_bus.DATA, q_data.pop_front());
        end
      end else begin
        check("data_blank", dvp_bus.DATA, 0);
      end
      if (efd) void'(q_frame.pop_front());
    end
  end

  initial begin
    int s;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (100) @(posedge CLK);
    #1;
    check("idle_fcnt", FRAME_CNT, 0);

    run_frames(2, 2'd0, 1'b0);
    run_frames(2, 2'd3, 1'b0);
    run_frames(1, 2'd2, 1'b0);
    run_frames(3, 2'($urandom_range(0, 3)), 1'b1);
    run_frames(1, 2'd1, 1'b0);

    @(posedge CLK);
    #1;
    s = cyc + 2;
    push_frame(s, 2'd0, 1'(done & 1));
    PATTERN_SEL = 2'd0;
    EN_TX = 1'b1;
    wait_cyc(s + (VS + VB) * L + 10);
    #3;
    RESET = 1'b1;
    #1;
    check("async_href", dvp_bus.HREF, 0);
    check("async_vsync", dvp_bus.VSYNC, 0);
    check("async_data", dvp_bus.DATA, 0);
    check("async_fcnt", FRAME_CNT, 0);
    EN_TX = 1'b0;
    q_frame.delete();
    q_data.delete();
    done = 0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (5) @(posedge CLK);

    run_frames(1, 2'd2, 1'b0);

    check("final_fcnt", FRAME_CNT, 1);
    check("data_q_empty", q_data.size(), 0);
    check("frame_q_empty", q_frame.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
